// File: rtl/xge_pkt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xge_pkt_pkg: shared types and constants for the 10GbE rx packet reader
// Rev 1.0
// ----------------------------------------------------------------------------
package xge_pkt_pkg;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } pkt_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    localparam logic [2:0] MOD_FULL       = 3'd0;
    localparam int         BYTES_PER_WORD = 8;

    // Valid bytes carried by an EOP word; a zero mod means a full word.
    function automatic logic [3:0] eop_bytes(input logic [2:0] mod);
        return (mod == MOD_FULL) ? 4'(BYTES_PER_WORD) : {1'b0, mod};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xge_pkt_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xge_pkt_fifo: synchronous FIFO of packet words, head held in registers
// Rev 1.0
// ----------------------------------------------------------------------------
module xge_pkt_fifo
    import xge_pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  pkt_word_t                wr_word,
    input  logic                     pop,
    output pkt_word_t                rd_word,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pkt_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push on full is legal then.
    assign do_push = push && (!full || do_pop);
    assign rd_word = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/xge_pkt_rx_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xge_pkt_rx_reader: MAC rx reader with framing check, stream output, stats
// Rev 1.0
// ----------------------------------------------------------------------------
module xge_pkt_rx_reader
    import xge_pkt_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic             pkt_rx_val,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [2:0]       out_mod,
    output logic             out_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] rx_pkt_cnt,
    output logic [CNT_W-1:0] rx_byte_cnt,
    output logic [CNT_W-1:0] rx_err_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rd_state_e         state;
    rd_state_e         state_next;
    logic              inflight;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic              eop_arrive;
    logic              fifo_empty;
    logic              pop;
    pkt_word_t         wr_word;
    pkt_word_t         rd_word;

    logic              push;
    logic              stray;
    logic              eop_push;
    logic              in_pkt;
    logic              err_flag;
    logic              word_err;
    logic              flag_now;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W+3:0]  byte_inc;
    logic [CNT_W+4:0]  byte_sum;

    assign occupancy  = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign eop_arrive = pkt_rx_val && pkt_rx_eop;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= pkt_rx_ren;
        end
    end

    // Read request is gated by reset and by an arriving EOP, both combinationally.
    always_comb begin
        state_next = state;
        pkt_rx_ren = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_rx_avail && (occupancy <= (CW+1)'(BUF_DEPTH - 2))) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (eop_arrive) begin
                    state_next = IDLE;
                end
                if (reset_156m25_n && (occupancy < (CW+1)'(BUF_DEPTH)) && !eop_arrive) begin
                    pkt_rx_ren = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push     = pkt_rx_val && inflight;
    assign stray    = pkt_rx_val && !inflight;
    assign eop_push = push && pkt_rx_eop;
    assign word_err = in_pkt ? pkt_rx_sop : !pkt_rx_sop;
    assign flag_now = err_flag | word_err;

    always_comb begin
        wr_word      = '0;
        wr_word.data = pkt_rx_data;
        wr_word.sop  = pkt_rx_sop;
        wr_word.eop  = pkt_rx_eop;
        wr_word.mod  = pkt_rx_mod;
        wr_word.err  = pkt_rx_eop && (pkt_rx_err || flag_now);
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_pkt   <= 1'b0;
            err_flag <= 1'b0;
            word_cnt <= '0;
        end else if (push) begin
            if (pkt_rx_eop) begin
                in_pkt   <= 1'b0;
                err_flag <= 1'b0;
                word_cnt <= '0;
            end else begin
                in_pkt   <= 1'b1;
                err_flag <= flag_now;
                word_cnt <= sat_inc(word_cnt);
            end
        end
    end

    // Wide sum so the byte counter can saturate instead of wrapping.
    assign byte_inc = {1'b0, word_cnt, 3'b000} + {{CNT_W{1'b0}}, eop_bytes(pkt_rx_mod)};
    assign byte_sum = {5'b0, rx_byte_cnt} + {1'b0, byte_inc};

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            rx_pkt_cnt    <= '0;
            rx_byte_cnt   <= '0;
            rx_err_cnt    <= '0;
            frame_err_cnt <= '0;
        end else if (stat_clr) begin
            rx_pkt_cnt    <= '0;
            rx_byte_cnt   <= '0;
            rx_err_cnt    <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (eop_push) begin
                rx_pkt_cnt  <= sat_inc(rx_pkt_cnt);
                rx_byte_cnt <= (byte_sum[CNT_W+4:CNT_W] != '0) ? '1 : byte_sum[CNT_W-1:0];
                if (pkt_rx_err) begin
                    rx_err_cnt <= sat_inc(rx_err_cnt);
                end
            end
            if ((eop_push && flag_now) || stray) begin
                frame_err_cnt <= sat_inc(frame_err_cnt);
            end
        end
    end

    assign pop = out_valid && out_ready;

    xge_pkt_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk_156m25),
        .rst_n   (reset_156m25_n),
        .push    (push),
        .wr_word (wr_word),
        .pop     (pop),
        .rd_word (rd_word),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = rd_word.data;
    assign out_sop   = rd_word.sop;
    assign out_eop   = rd_word.eop;
    assign out_mod   = rd_word.mod;
    assign out_err   = rd_word.err;

endmodule
`default_nettype wire
